// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory server and its banks.
package imem_pkg;

  typedef enum logic [1:0] {
    LD_IDLE = 2'd0,
    LD_LEN  = 2'd1,
    LD_DATA = 2'd2,
    LD_DONE = 2'd3
  } imem_ld_state_t;

  localparam int unsigned DEPTH_WORDS_DEF = 4096;
  localparam logic [15:0] HALF_ZERO       = 16'h0000;

  // Little-endian byte lane insert used by the loader for both length and data words.
  function automatic logic [31:0] put_byte(input logic [31:0] word,
                                           input logic [1:0]  idx,
                                           input logic [7:0]  b);
    logic [31:0] r;
    r = word;
    case (idx)
      2'd0:    r[7:0]   = b;
      2'd1:    r[15:8]  = b;
      2'd2:    r[23:16] = b;
      default: r[31:24] = b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/imem_bank.sv
// One half of the instruction memory: synchronous-read RAM with a separate write port.
module imem_bank #(
  parameter int unsigned DEPTH = 2048,
  parameter int unsigned IW    = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [IW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [IW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem_r [DEPTH];
  logic [31:0] rdata_r;

  // Storage array: contents survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Read-first registered read port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_r <= 32'h0000_0000;
    end else if (re) begin
      rdata_r <= mem_r[raddr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/imem_server.sv
// Fetch-side instruction memory with split even/odd banks for unaligned 32-bit reads,
// plus a UART byte-stream loader that reprograms it.
module imem_server
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DEPTH_WORDS_DEF
) (
  input  logic        clk,
  input  logic        Rst_n,
  input  logic        imem_en,
  input  logic [31:0] imem_addr,
  output logic [31:0] imem_dout,
  input  logic        prog_start,
  input  logic        prog_valid,
  input  logic [7:0]  prog_byte,
  output logic        memcon_prog_ena,
  output logic        prog_done,
  output logic        prog_err
);

  localparam int unsigned AW  = $clog2(DEPTH_WORDS);
  localparam int unsigned BAW = (AW > 1) ? AW - 1 : 1;
  localparam int unsigned BD  = DEPTH_WORDS / 2;

  logic [AW-1:0]  w_s;
  logic [AW:0]    w_inc_s, even_full_s;
  logic [BAW-1:0] even_idx_s, odd_idx_s, wr_idx_s;
  logic           oor_s, top_s, addr_unused_s;
  logic [31:0]    even_rd_s, odd_rd_s, lo_s, hi_s, rd_word_s;
  logic           en_r, h_r, w0_r, top_r, oor_r;
  logic [31:0]    dout_r;

  imem_ld_state_t state_r, next_state_s;
  logic [1:0]     byte_cnt_r;
  logic [31:0]    len_r, word_r, len_full_s, wdata_s;
  logic [AW-1:0]  wptr_r;
  logic           last_byte_s, wr_s, wptr_last_s, len_bad_s;
  logic           ena_s, done_s, err_set_s;
  logic           ena_r, done_r, err_r;

  assign addr_unused_s = imem_addr[0];
  assign w_s           = imem_addr[AW+1:2];
  assign w_inc_s       = {1'b0, w_s} + {{AW{1'b0}}, 1'b1};
  assign even_full_s   = w_s[0] ? w_inc_s : {1'b0, w_s};
  assign even_idx_s    = BAW'(even_full_s >> 1);
  assign odd_idx_s     = BAW'(w_s >> 1);
  assign oor_s         = |imem_addr[31:AW+2];
  assign top_s         = (w_s == AW'(DEPTH_WORDS - 1));

  assign last_byte_s = prog_valid && (byte_cnt_r == 2'd3);
  assign len_full_s  = put_byte(len_r, 2'd3, prog_byte);
  assign wdata_s     = put_byte(word_r, 2'd3, prog_byte);
  assign len_bad_s   = (len_full_s > 32'(DEPTH_WORDS));
  assign wr_s        = (state_r == LD_DATA) && last_byte_s && !prog_start;
  assign wptr_last_s = ((32'(wptr_r) + 32'd1) == len_r);
  assign wr_idx_s    = BAW'(wptr_r >> 1);

  imem_bank #(.DEPTH(BD), .IW(BAW)) u_even (
    .clk(clk), .rst_n(Rst_n), .we(wr_s && !wptr_r[0]), .waddr(wr_idx_s), .wdata(wdata_s),
    .re(imem_en), .raddr(even_idx_s), .rdata(even_rd_s)
  );

  imem_bank #(.DEPTH(BD), .IW(BAW)) u_odd (
    .clk(clk), .rst_n(Rst_n), .we(wr_s && wptr_r[0]), .waddr(wr_idx_s), .wdata(wdata_s),
    .re(imem_en), .raddr(odd_idx_s), .rdata(odd_rd_s)
  );

  // Address attributes travelling alongside the bank read.
  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      en_r  <= 1'b0;
      h_r   <= 1'b0;
      w0_r  <= 1'b0;
      top_r <= 1'b0;
      oor_r <= 1'b0;
    end else begin
      en_r <= imem_en;
      if (imem_en) begin
        h_r   <= imem_addr[1] | addr_unused_s & 1'b0;
        w0_r  <= w_s[0];
        top_r <= top_s;
        oor_r <= oor_s;
      end
    end
  end

  // Word w comes from whichever bank holds its parity; w+1 from the other one.
  always_comb begin
    lo_s = w0_r ? odd_rd_s : even_rd_s;
    hi_s = w0_r ? even_rd_s : odd_rd_s;
    if (oor_r) begin
      rd_word_s = 32'h0000_0000;
    end else if (h_r) begin
      rd_word_s = {(top_r ? HALF_ZERO : hi_s[15:0]), lo_s[31:16]};
    end else begin
      rd_word_s = lo_s;
    end
  end

  // Output register: zero during a load, otherwise holds between reads.
  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      dout_r <= 32'h0000_0000;
    end else if (ena_s) begin
      dout_r <= 32'h0000_0000;
    end else if (en_r) begin
      dout_r <= rd_word_s;
    end else begin
      dout_r <= dout_r;
    end
  end

  // Loader state register and registered status outputs.
  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_r <= LD_IDLE;
      ena_r   <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= next_state_s;
      ena_r   <= ena_s;
      done_r  <= done_s;
      if (prog_start) begin
        err_r <= 1'b0;
      end else if (err_set_s) begin
        err_r <= 1'b1;
      end
    end
  end

  // Loader next-state logic; a start pulse always wins over a byte in the same cycle.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      LD_IDLE: begin
        if (prog_start) next_state_s = LD_LEN;
        else            next_state_s = LD_IDLE;
      end
      LD_LEN: begin
        if (prog_start)                   next_state_s = LD_LEN;
        else if (!last_byte_s)            next_state_s = LD_LEN;
        else if (len_full_s == 32'd0)     next_state_s = LD_DONE;
        else if (len_bad_s)               next_state_s = LD_IDLE;
        else                              next_state_s = LD_DATA;
      end
      LD_DATA: begin
        if (prog_start)                   next_state_s = LD_LEN;
        else if (wr_s && wptr_last_s)     next_state_s = LD_DONE;
        else                              next_state_s = LD_DATA;
      end
      LD_DONE: next_state_s = LD_IDLE;
      default: next_state_s = LD_IDLE;
    endcase
  end

  // Loader outputs, decoded from the upcoming state so they register in step with it.
  always_comb begin
    ena_s     = (next_state_s == LD_LEN) || (next_state_s == LD_DATA);
    done_s    = (next_state_s == LD_DONE);
    err_set_s = (state_r == LD_LEN) && last_byte_s && !prog_start && len_bad_s;
  end

  // Loader byte counter, length, write pointer and word assembly.
  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      byte_cnt_r <= 2'd0;
      len_r      <= 32'd0;
      wptr_r     <= '0;
      word_r     <= 32'd0;
    end else if (prog_start && (state_r != LD_DONE)) begin
      byte_cnt_r <= 2'd0;
      len_r      <= 32'd0;
      wptr_r     <= '0;
      word_r     <= 32'd0;
    end else if (prog_valid && (state_r == LD_LEN)) begin
      byte_cnt_r <= byte_cnt_r + 2'd1;
      len_r      <= put_byte(len_r, byte_cnt_r, prog_byte);
    end else if (prog_valid && (state_r == LD_DATA)) begin
      byte_cnt_r <= byte_cnt_r + 2'd1;
      word_r     <= put_byte(word_r, byte_cnt_r, prog_byte);
      if (byte_cnt_r == 2'd3) begin
        wptr_r <= wptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
    end
  end

  assign imem_dout       = dout_r;
  assign memcon_prog_ena = ena_r;
  assign prog_done       = done_r;
  assign prog_err        = err_r;

endmodule

// File: tb/tb_imem_server.sv
// Scoreboard bench for imem_server: loads memory images, then checks reads against a word model.
module tb_imem_server;

  localparam int DW = 4096;
  localparam int AW = 12;

  logic        clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        imem_en = 1'b0;
  logic [31:0] imem_addr = 32'd0;
  logic [31:0] imem_dout;
  logic        prog_start = 1'b0;
  logic        prog_valid = 1'b0;
  logic [7:0]  prog_byte = 8'd0;
  logic        memcon_prog_ena, prog_done, prog_err;

  imem_server #(.DEPTH_WORDS(DW)) dut (
    .clk(clk), .Rst_n(Rst_n), .imem_en(imem_en), .imem_addr(imem_addr), .imem_dout(imem_dout),
    .prog_start(prog_start), .prog_valid(prog_valid), .prog_byte(prog_byte),
    .memcon_prog_ena(memcon_prog_ena), .prog_done(prog_done), .prog_err(prog_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] model [DW];
  logic [31:0] exp_q [$];
  logic [31:0] wbuf [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [31:0] a);
    logic [AW-1:0] w;
    logic [31:0]   lo;
    logic [15:0]   hi;
    if (a[31:AW+2] != '0) return 32'h0;
    w  = a[AW+1:2];
    lo = model[int'(w)];
    if (!a[1]) return lo;
    if (int'(w) == DW - 1) hi = 16'h0000;
    else                   hi = model[int'(w) + 1][15:0];
    return {hi, lo[31:16]};
  endfunction

  task automatic rd(input logic [31:0] a);
    imem_en = 1'b1;
    imem_addr = a;
    exp_q.push_back(exp_rd(a));
    @(negedge clk);
    imem_en = 1'b0;
    @(negedge clk);
    if (exp_q.size() == 0) check("rd_queue_empty", 32'd1, 32'd0);
    else                   check("rd", imem_dout, exp_q.pop_front());
  endtask

  task automatic pstart();
    prog_start = 1'b1;
    @(negedge clk);
    prog_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit chk_ena);
    repeat (gap) @(negedge clk);
    prog_valid = 1'b1;
    prog_byte = b;
    @(negedge clk);
    prog_valid = 1'b0;
    if (chk_ena) check("ena_busy", 32'(memcon_prog_ena), 32'd1);
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps, input bit chk_ena, input bit last);
    logic [31:0] t;
    t = w;
    for (int b = 0; b < 4; b++)
      send_byte(t[8*b +: 8], gaps ? int'($urandom_range(0, 3)) : 0, chk_ena && !(last && b == 3));
  endtask

  // Full load of wbuf with the given length field; expects a clean completion.
  task automatic load(input logic [31:0] len, input bit gaps, input bit chk_ena);
    pstart();
    check("ena_start", 32'(memcon_prog_ena), 32'd1);
    send_word(len, gaps, chk_ena, wbuf.size() == 0);
    for (int i = 0; i < wbuf.size(); i++)
      send_word(wbuf[i], gaps, chk_ena, i == wbuf.size() - 1);
    check("done_pulse", 32'(prog_done), 32'd1);
    check("ena_end", 32'(memcon_prog_ena), 32'd0);
    for (int i = 0; i < wbuf.size(); i++) model[i] = wbuf[i];
    @(negedge clk);
    check("done_low", 32'(prog_done), 32'd0);
  endtask

  initial begin
    logic [31:0] last;
    #12;
    check("rst_dout", imem_dout, 32'd0);
    check("rst_ena", 32'(memcon_prog_ena), 32'd0);
    check("rst_done", 32'(prog_done), 32'd0);
    check("rst_err", 32'(prog_err), 32'd0);
    @(negedge clk);
    Rst_n = 1'b1;
    @(negedge clk);

    // Fill every word (len == DEPTH is the largest legal length).
    wbuf.delete();
    for (int i = 0; i < DW; i++) wbuf.push_back({16'(i) ^ 16'h5A5A, 16'(i)});
    load(32'd4096, 1'b0, 1'b0);

    wbuf.delete();
    wbuf.push_back(32'h0050_0013);
    wbuf.push_back(32'h0010_0093);
    load(32'd2, 1'b0, 1'b1);

    rd(32'h0000_0004);
    check("rd_aligned_const", imem_dout, 32'h0010_0093);
    rd(32'h0000_0002);
    check("rd_half_const", imem_dout, 32'h0093_0050);
    rd(32'h0000_0000);
    rd(32'h0000_0003);
    rd(32'(4 * DW - 2));
    check("rd_top_upper", {16'd0, imem_dout[31:16]}, 32'd0);
    rd(32'(4 * DW - 4));
    rd(32'h8000_0000);
    rd(32'h0000_4000);
    for (int i = 0; i < 8; i++) rd(32'($urandom_range(0, 4 * DW - 1)));

    // Output must hold while the enable is low.
    rd(32'h0000_0010);
    last = exp_rd(32'h0000_0010);
    for (int i = 0; i < 4; i++) begin
      imem_addr = 32'($urandom);
      @(negedge clk);
      check("hold", imem_dout, last);
    end

    // Oversized length: error, back to idle, nothing written.
    pstart();
    send_word(32'h0000_1001, 1'b0, 1'b0, 1'b1);
    check("err_set", 32'(prog_err), 32'd1);
    check("err_ena", 32'(memcon_prog_ena), 32'd0);
    @(negedge clk);
    check("err_idle", 32'(memcon_prog_ena), 32'd0);
    check("err_sticky", 32'(prog_err), 32'd1);
    rd(32'h0000_0000);
    rd(32'h0000_0004);
    wbuf.delete();
    load(32'd0, 1'b0, 1'b0);
    check("err_clear", 32'(prog_err), 32'd0);

    // Byte stream with random stalls.
    wbuf.delete();
    wbuf.push_back(32'hDEAD_BEEF);
    wbuf.push_back(32'h1357_9BDF);
    load(32'd2, 1'b1, 1'b1);
    rd(32'h0000_0000);
    rd(32'h0000_0004);
    rd(32'h0000_0002);

    // Asynchronous reset in the middle of the second data word.
    pstart();
    send_word(32'd3, 1'b0, 1'b1, 1'b0);
    send_word(32'hCAFE_F00D, 1'b0, 1'b1, 1'b0);
    send_byte(8'hAA, 0, 1'b1);
    send_byte(8'hBB, 0, 1'b1);
    model[0] = 32'hCAFE_F00D;
    #2 Rst_n = 1'b0;
    #1 check("rst_mid_ena", 32'(memcon_prog_ena), 32'd0);
    @(negedge clk);
    Rst_n = 1'b1;
    @(negedge clk);
    rd(32'h0000_0000);
    rd(32'h0000_0004);

    // Restart mid-DATA: the new stream must write from word 0 again.
    pstart();
    send_word(32'd2, 1'b0, 1'b1, 1'b0);
    send_word(32'h1122_3344, 1'b0, 1'b1, 1'b0);
    model[0] = 32'h1122_3344;
    send_byte(8'h99, 0, 1'b1);
    pstart();
    check("restart_ena", 32'(memcon_prog_ena), 32'd1);
    send_word(32'd1, 1'b0, 1'b1, 1'b0);
    send_word(32'h5566_7788, 1'b0, 1'b1, 1'b1);
    check("restart_done", 32'(prog_done), 32'd1);
    model[0] = 32'h5566_7788;
    @(negedge clk);
    rd(32'h0000_0000);
    rd(32'h0000_0004);
    rd(32'h0000_0002);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/imem_server.md
# imem_server

Instruction-memory responder answering the fetch stage's `imem_en`/`imem_addr` requests with `imem_dout` one cycle later. Memory is split into even-word and odd-word banks so any halfword-aligned address, including a 32-bit instruction straddling two words after a compressed one, is served in a single access. A byte-stream loader fed by the UART receiver also lives here. It reprograms the memory and drives `memcon_prog_ena`, which holds fetch in its reset state while loading.

## Interface
- `DEPTH_WORDS`, 4096: total 32-bit words; power of two, at least 2.
- `clk` in 1: system clock.
- `Rst_n` in 1: reset, asynchronous and active-low. One clock domain only.
- `imem_en` in 1: fetch read enable.
- `imem_addr` in 32: byte address; bit 0 is ignored.
- `imem_dout` out 32: instruction word, little-endian halfwords.
- `prog_start` in 1: single-cycle pulse that begins a load.
- `prog_valid` in 1: `prog_byte` is valid this cycle.
- `prog_byte` in 8: load stream byte.
- `memcon_prog_ena` out 1: load in progress; fetch holds its PC at 0.
- `prog_done` out 1: one-cycle pulse when a load completes.
- `prog_err` out 1: sticky flag for a length that is out of range.

## Operation
- Read address decode:
  - Word index `w = imem_addr[AW+1:2]`, with `AW = log2(DEPTH_WORDS)`. Halfword select `h = imem_addr[1]`.
  - Words w and w+1 always sit in different banks.
  - Even bank index = (w even ? w : w+1) >> 1. Odd bank index = (w odd ? w : w+1) >> 1.
- Output select, using `h` and `w[0]` registered alongside the read:
  - h=0: `imem_dout = word(w)`.
  - h=1: `imem_dout = {word(w+1)[15:0], word(w)[31:16]}`.
  - If w = DEPTH_WORDS-1 and h=1, the upper half is 16'h0000 (no wrap).
  - Any address with bits above AW+1 nonzero returns 32'h0.
- While `memcon_prog_ena` is high, `imem_dout` is forced to 0.
- Loader FSM states: IDLE, LEN, DATA, DONE.
  - IDLE: `prog_start` -> LEN, clearing the byte counter, `len` and `wptr`.
  - LEN: takes 4 valid bytes into `len`, little-endian. After the 4th byte: len==0 -> DONE; len > DEPTH_WORDS -> set `prog_err`, go to IDLE; otherwise -> DATA.
  - DATA: assembles 4 valid bytes into a little-endian word. On the 4th byte it writes bank `wptr[0]` at index `wptr>>1` and increments `wptr`. When `wptr+1 == len`, it writes the word and goes to DONE.
  - DONE: `prog_done`=1 for one cycle, then IDLE.
  - `prog_start` in LEN or DATA restarts at LEN with counters cleared. Words already written stay written.
  - `prog_err` clears on `prog_start` or reset.
- `memcon_prog_ena` = (state is LEN or DATA), registered from the state.
- Memory contents are never cleared by reset or by a load.

## Timing
- Reset values: state IDLE; `imem_dout`, `memcon_prog_ena`, `prog_done` and `prog_err` all 0; internal counters 0.
- Read latency is 1 cycle:
  - Address sampled at edge N with `imem_en`=1 -> data on `imem_dout` after edge N+1.
  - With `imem_en`=0, `imem_dout` holds its last value.
- Writes take effect at the clock edge of the 4th data byte.
  - A read of the same word on that edge returns the old data (read-first).
  - This case only occurs during a load, when the output is forced to 0 anyway.
- `prog_valid` gaps of any length are allowed; bytes count only when `prog_valid`=1.
- `prog_valid` in IDLE or DONE is ignored.
- `Rst_n` asserted mid-load:
  - FSM returns to IDLE immediately (asynchronously) and `memcon_prog_ena` drops.
  - The partial word is discarded.
- `memcon_prog_ena` falls on the same edge that raises `prog_done`. Fetch resumes from address 0 the next cycle.

## Structure
- `imem_pkg` holds the loader state enum `imem_ld_state_t`, the default `DEPTH_WORDS`, and a `HALF_ZERO` constant.
- Sub-module `imem_bank`: `DEPTH_WORDS/2` x 32 synchronous-read RAM with one write port, instantiated twice (even and odd banks).
- Bank select, output muxing and the loader FSM live in `imem_server`.

## Test plan
- Load: start, len bytes 02 00 00 00, then 13 00 50 00 93 00 10 00 -> word0=0x00500013, word1=0x00100093; `memcon_prog_ena` high throughout the load; `prog_done` pulses once.
- Aligned read: addr 0x4 -> next cycle `imem_dout`=0x00100093. Halfword read: addr 0x2 -> 0x00930050.
- Top boundary: addr = 4*DEPTH_WORDS-2 -> upper half 0. Addr 0x8000_0000 -> 0x00000000.
- Error path: len bytes 01 10 00 00 (4097 > 4096) -> `prog_err`=1, FSM back in IDLE, memory unchanged. A following `prog_start` clears `prog_err`.
- Interrupted load: deassert `Rst_n` after 2 data bytes -> `memcon_prog_ena`=0 immediately, previously written words intact. A `prog_start` mid-DATA restarts at LEN with `wptr`=0.
- Hold: `imem_en`=0 while `imem_addr` changes -> `imem_dout` stable. `prog_valid` stalls between bytes -> same final memory image as a contiguous stream.
